// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit carry chain is cut into GROUP-bit lookahead groups; each of
// the STAGES register stages resolves an equal share of those groups, low
// groups first. Valid/ready handshake on both sides, full throughput.
// Optional feature macro: CLA_SAT_EN (signed saturation when i_sat was set).
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  input  logic             i_sub,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned GPS  = NGRP / STAGES;

  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] ld;

  // Load enables: a stage loads when empty or when the stage after it loads
  // (the output stage "loads downstream" when i_ready is high).
  always_comb begin : flow
    logic nxt;
    nxt = i_ready;
    ld  = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      ld[STAGES-1-j] = ~v_vec[STAGES-1-j] | nxt;
      nxt            = ld[STAGES-1-j];
    end
  end

  assign o_ready = ld[0] & ~i_rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q, c_q, cm_q, sat_q;
    logic [WIDTH-1:0] a_q, b_q, s_q;

    logic             vin, c_in, sat_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_d, cm_d;
    logic [WIDTH-1:0] s_d;

    if (k == 0) begin : g_src
      // Operand prep: subtraction is A + ~B + 1, so i_carry is ignored then.
      assign vin    = i_valid;
      assign a_in   = i_add1;
      assign b_in   = i_sub ? ~i_add2 : i_add2;
      assign c_in   = i_sub | i_carry;
      assign s_in   = '0;
      assign sat_in = i_sat;
    end else begin : g_src
      assign vin    = g_stage[k-1].v_q;
      assign a_in   = g_stage[k-1].a_q;
      assign b_in   = g_stage[k-1].b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign s_in   = g_stage[k-1].s_q;
      assign sat_in = g_stage[k-1].sat_q;
    end

    // Resolve this stage's groups: per-bit sums inside a group, group carry
    // chained through the group generate/propagate terms.
    always_comb begin : resolve
      logic        gg, pg, cb, gb, pb;
      int unsigned idx;
      s_d  = s_in;
      c_d  = c_in;
      cm_d = 1'b0;
      gg   = 1'b0;
      pg   = 1'b1;
      cb   = 1'b0;
      gb   = 1'b0;
      pb   = 1'b0;
      idx  = 0;
      for (int unsigned g = k * GPS; g < (k + 1) * GPS; g++) begin
        gg = 1'b0;
        pg = 1'b1;
        cb = c_d;
        for (int unsigned i = 0; i < GROUP; i++) begin
          idx      = g * GROUP + i;
          gb       = a_in[idx] & b_in[idx];
          pb       = a_in[idx] | b_in[idx];
          s_d[idx] = a_in[idx] ^ b_in[idx] ^ cb;
          if (idx == WIDTH - 1) cm_d = cb;
          cb = gb | (pb & cb);
          gg = gb | (pb & gg);
          pg = pg & pb;
        end
        c_d = gg | (pg & c_d);
      end
    end

    // Stage register: holds while the next stage is stalled.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        cm_q  <= 1'b0;
        sat_q <= 1'b0;
      end else if (ld[k]) begin
        v_q <= vin;
        if (vin) begin
          a_q   <= a_in;
          b_q   <= b_in;
          s_q   <= s_d;
          c_q   <= c_d;
          cm_q  <= cm_d;
          sat_q <= sat_in;
        end
      end
    end

    assign v_vec[k] = v_q;

    // Operand bits already consumed (and flags of a disabled feature) are
    // carried for regularity; collecting them here keeps them out of lint.
    logic unused_stage;
    assign unused_stage = ^{a_q, b_q, s_q, c_q, cm_q, sat_q};
  end

  logic [WIDTH-1:0] res_raw;

  assign o_valid = g_stage[STAGES-1].v_q;
  assign o_carry = g_stage[STAGES-1].c_q;
  assign o_ovf   = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].cm_q;
  assign res_raw = g_stage[STAGES-1].s_q;

`ifdef CLA_SAT_EN
  logic             sat_last;
  logic [WIDTH-1:0] a_last;
  assign sat_last = g_stage[STAGES-1].sat_q;
  assign a_last   = g_stage[STAGES-1].a_q;

  // Clamp toward the sign of A on signed overflow; carry/ovf stay raw.
  always_comb begin
    o_result = res_raw;
    if (sat_last && o_ovf) begin
      o_result = a_last[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign o_result = res_raw;
`endif

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (W=8, G=4, S=2).
module tb_pipelined_cla_addsub;

  localparam int unsigned W = 8;
  localparam int unsigned G = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub, sat;
  logic         out_valid, out_ready;
  logic [W-1:0] res;
  logic         cout, ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit lat_en  = 1'b0;
  bit rand_rdy = 1'b0;

  logic [W-1:0] exp_res_q[$];
  logic         exp_c_q[$];
  logic         exp_ovf_q[$];
  int           acc_cyc_q[$];

  pipelined_cla_addsub #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_add1  (a),
    .i_add2  (b),
    .i_carry (cin),
    .i_sub   (sub),
    .i_sat   (sat),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_result(res),
    .o_carry (cout),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic tsat,
                       output logic [W-1:0] r, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ta);
    ub = int'(tb_);
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    if (ts) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + int'(tc);
      c  = (ur >= (1 << W));
      sr = sa + sb + int'(tc);
    end
    r = ur[W-1:0];
    o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
`ifdef CLA_SAT_EN
    if (tsat && o) r = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`else
    if (tsat) r = r;
`endif
  endtask

  // Monitor: score accepts into the model, compare emits, watch stalls.
  logic         hold_p = 1'b0;
  logic [W-1:0] h_res;
  logic         h_c, h_ovf;
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        check("hold_result", res, h_res);
        check("hold_carry", cout, h_c);
        check("hold_ovf", ovf, h_ovf);
      end
      if (out_valid && out_ready) begin
        check("result_expected", exp_res_q.size() != 0, 1);
        if (exp_res_q.size() != 0) begin
          check("result", res, exp_res_q.pop_front());
          check("carry", cout, exp_c_q.pop_front());
          check("ovf", ovf, exp_ovf_q.pop_front());
          if (acc_cyc_q[0] >= 0 && lat_en) check("latency", cyc - acc_cyc_q[0], S);
          void'(acc_cyc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        logic [W-1:0] r;
        logic c, o;
        model(a, b, cin, sub, sat, r, c, o);
        exp_res_q.push_back(r);
        exp_c_q.push_back(c);
        exp_ovf_q.push_back(o);
        acc_cyc_q.push_back(lat_en ? cyc : -1);
      end
      hold_p = out_valid && !out_ready;
      h_res  = res;
      h_c    = cout;
      h_ovf  = ovf;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic tsat);
    a = ta; b = tb_; cin = tc; sub = ts; sat = tsat;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    check("accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic tsat,
                          input logic [W-1:0] er, input logic ec, input logic eo);
    issue(ta, tb_, tc, ts, tsat);
    for (int i = 1; i < S; i++) begin
      check({tag, "_early"}, out_valid, 0);
      tick();
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, res, er);
    check({tag, "_carry"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_res_q.size() != 0; i++) tick();
    check("drain", exp_res_q.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_carry", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check("rel_ready", in_ready, 1);
    tick();
    lat_en = 1'b1;

    // Directed cases
    directed("add_5a_33", 8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, 8'h8E, 1'b0, 1'b1);
    directed("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    directed("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    directed("sub_cin_ign", 8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef CLA_SAT_EN
    directed("sat_add", 8'h70, 8'h70, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    directed("sat_sub", 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
`else
    directed("sat_add", 8'h70, 8'h70, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1);
    directed("sat_sub", 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    // Back-to-back random ops at full throughput
    for (int i = 0; i < 16; i++)
      issue(rnd(), rnd(), 1'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Stall with full pipeline
    lat_en = 1'b0;
    out_ready = 1'b0;
    issue(rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    issue(rnd(), rnd(), 1'b1, 1'b1, 1'b0);
    a = rnd(); b = rnd(); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    issue(a, b, 1'b1, 1'b0, 1'b0);
    drain();

    // Random backpressure and input gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(rnd(), rnd(), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) tick();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two operations in flight
    out_ready = 1'b0;
    issue(rnd(), rnd(), 1'b0, 1'b0, 1'b0);
    issue(rnd(), rnd(), 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    exp_res_q.delete(); exp_c_q.delete(); exp_ovf_q.delete(); acc_cyc_q.delete();
    tick();
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_carry", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_valid", out_valid, 0);
      tick();
    end

    // Pipeline usable again after reset
    lat_en = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(rnd(), rnd(), 1'($urandom), 1'($urandom), 1'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
